// File: rtl/shift_add_mult_if.sv
// Handshake and operand/result bundle for shift_add_mult.
// The master side supplies the request and operands; the slave side is the multiplier.
interface shift_add_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 START;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 BUSY;
  logic                 DONE;
  logic [2*WIDTH-1:0]   PRODUCT;

  modport master (
    output START, A, B,
    input  BUSY, DONE, PRODUCT
  );

  modport slave (
    input  START, A, B,
    output BUSY, DONE, PRODUCT
  );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier with START/BUSY/DONE handshake.
// Stops early once the remaining multiplier bits are all zero.
// Optional macro SHIFT_ADD_MULT_SIGNED_EN: treat A/B as two's complement
// (multiply magnitudes, negate the result when the operand signs differ).
module shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  shift_add_mult_if.slave  bus
);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, acc_q, product_q, result;
  logic [WIDTH-1:0] mult_q, a_mag, b_mag;
  logic             load, mult_zero;

  assign load      = (state_q == IDLE) && bus.START;
  assign mult_zero = (mult_q == '0);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic neg_q;

  // Magnitudes of the signed operands; the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    a_mag  = bus.A[WIDTH-1] ? WIDTH'(-bus.A) : bus.A;
    b_mag  = bus.B[WIDTH-1] ? WIDTH'(-bus.B) : bus.B;
    result = neg_q ? PW'(-acc_q) : acc_q;
  end

  // Result sign, captured with the operands.
  always_ff @(posedge CLK) begin
    if (!RST_N)    neg_q <= 1'b0;
    else if (load) neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
  end
`else
  // Unsigned operands pass straight through.
  always_comb begin
    a_mag  = bus.A;
    b_mag  = bus.B;
    result = acc_q;
  end
`endif

  // Control state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and Moore handshake outputs.
  always_comb begin
    state_d  = state_q;
    bus.BUSY = 1'b0;
    bus.DONE = 1'b0;
    unique case (state_q)
      IDLE:    if (bus.START) state_d = RUN;
      RUN: begin
        bus.BUSY = 1'b1;
        if (mult_zero) state_d = DONE_ST;
      end
      DONE_ST: begin
        bus.BUSY = 1'b1;
        bus.DONE = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load, shift/accumulate steps, result capture.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      if (load) begin
        mcand_q <= {{WIDTH{1'b0}}, a_mag};
        mult_q  <= b_mag;
        acc_q   <= '0;
      end else if (state_q == RUN) begin
        if (!mult_zero) begin
          if (mult_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q <= mcand_q << 1;
          mult_q  <= mult_q >> 1;
        end else begin
          product_q <= result;
        end
      end
    end
  end

  assign bus.PRODUCT = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed-vector bench for shift_add_mult (WIDTH=8 and WIDTH=16 instances).
module tb_shift_add_mult;
  logic CLK = 1'b0;
  logic RST_N;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_prod;

  always #5 CLK = ~CLK;

  shift_add_mult_if #(.WIDTH(8))  u_if ();
  shift_add_mult_if #(.WIDTH(16)) u_if16 ();

  shift_add_mult #(.WIDTH(8))  u_dut   (.CLK(CLK), .RST_N(RST_N), .bus(u_if.slave));
  shift_add_mult #(.WIDTH(16)) u_dut16 (.CLK(CLK), .RST_N(RST_N), .bus(u_if16.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the 8-bit DUT idle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int k);
    int lat;
    u_if.A = a; u_if.B = b; u_if.START = 1'b1;
    @(posedge CLK); #1;
    u_if.START = 1'b0;
    u_if.A = ~a; u_if.B = ~b;
    check({tag, "_busy_run"}, u_if.BUSY, 1'b1);
    check({tag, "_prod_held"}, u_if.PRODUCT, last_prod);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (u_if.DONE) begin lat = c; break; end
    end
    check({tag, "_latency"}, lat, k + 1);
    check({tag, "_product"}, u_if.PRODUCT, exp);
    check({tag, "_busy_done"}, u_if.BUSY, 1'b1);
    last_prod = exp;
    @(posedge CLK); #1;
    check({tag, "_idle"}, {u_if.BUSY, u_if.DONE}, 2'b00);
  endtask

  initial begin : main
    int lat, dones;
    bit    exp_busy [1:11];
    bit    exp_done [1:11];
    logic [15:0] exp_p [1:11];

    RST_N = 1'b0;
    u_if.START = 1'b0; u_if.A = '0; u_if.B = '0;
    u_if16.START = 1'b0; u_if16.A = '0; u_if16.B = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check("reset_state", {u_if.BUSY, u_if.DONE, u_if.PRODUCT}, 18'h0);
    last_prod = '0;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    run_op("s_13x11",   8'd13,   8'd11,   16'h008F, 4);
    run_op("s_m3x5",    8'hFD,   8'd5,    16'hFFF1, 3);
    run_op("s_m128sq",  8'h80,   8'h80,   16'h4000, 8);
    run_op("s_127xm128",8'd127,  8'h80,   16'hC080, 8);
    run_op("s_m1x0",    8'hFF,   8'd0,    16'h0000, 0);
`else
    run_op("u_13x11",   8'd13,   8'd11,   16'h008F, 4);
    run_op("u_255sq",   8'd255,  8'd255,  16'hFE01, 8);
    run_op("u_ABx0",    8'hAB,   8'd0,    16'h0000, 0);
    run_op("u_1x80",    8'd1,    8'h80,   16'h0080, 8);
`endif

    // Back-to-back with START held: 3*2 (k=2), then 9*9 (k=4) accepted at edge 5.
    for (int i = 1; i <= 11; i++) begin
      exp_busy[i] = !(i == 4 || i == 11);
      exp_done[i] = (i == 3 || i == 10);
      exp_p[i]    = (i >= 3 && i < 10) ? 16'd6 : (i >= 10 ? 16'd81 : last_prod);
    end
    u_if.A = 8'd3; u_if.B = 8'd2; u_if.START = 1'b1;
    @(posedge CLK); #1;
    u_if.A = 8'd9; u_if.B = 8'd9;
    for (int i = 1; i <= 11; i++) begin
      @(posedge CLK); #1;
      check($sformatf("b2b_busy_e%0d", i), u_if.BUSY, exp_busy[i]);
      check($sformatf("b2b_done_e%0d", i), u_if.DONE, exp_done[i]);
      check($sformatf("b2b_prod_e%0d", i), u_if.PRODUCT, exp_p[i]);
      if (i == 6) u_if.START = 1'b0;
      if (i == 7) begin u_if.START = 1'b1; u_if.A = 8'd1; u_if.B = 8'd1; end
      if (i == 8) u_if.START = 1'b0;
    end
    last_prod = 16'd81;

    // Reset in the middle of a run aborts it without a DONE pulse.
    u_if.A = 8'd200; u_if.B = 8'd200; u_if.START = 1'b1;
    @(posedge CLK); #1;
    u_if.START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    check("rst_mid_run", {u_if.BUSY, u_if.DONE, u_if.PRODUCT}, 18'h0);
    last_prod = '0;
    dones = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (u_if.DONE || u_if.BUSY) dones++;
    end
    check("rst_no_done", dones, 0);
    run_op("post_rst_7x9", 8'd7, 8'd9, 16'd63, 4);

    // WIDTH=16 instance.
    u_if16.A = 16'hFFFF; u_if16.B = 16'h8001; u_if16.START = 1'b1;
    @(posedge CLK); #1;
    u_if16.START = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (u_if16.DONE) begin lat = c; break; end
    end
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    check("w16_latency", lat, 16);
    check("w16_product", u_if16.PRODUCT, 32'h0000_7FFF);
`else
    check("w16_latency", lat, 17);
    check("w16_product", u_if16.PRODUCT, 32'h8000_7FFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
